spart_bus_if: RTL and testbench
===============================

SPART_BUS_IF -- requirements
Module: spart_bus_if

Interface
REQ-001 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 Port: iocs  in  1  chip select; a bus access occurs in any cycle with iocs=1.
REQ-004 Port: iorw  in  1  1=read (block drives databus), 0=write (block samples databus).
REQ-005 Port: ioaddr  in  2  register select: 00 data, 01 status, 10 divisor low, 11 divisor high.
REQ-006 Port: databus  inout  8  bidirectional data.
REQ-007 Port: rda  out  1  receive data available.
REQ-008 Port: tbr  out  1  transmit buffer ready (holding register empty).
REQ-009 Port: rx_valid  in  1  one-cycle strobe from receiver; rx_data valid.
REQ-010 Port: rx_data  in  8  received byte.
REQ-011 Port: tx_busy  in  1  transmitter shifting a byte.
REQ-012 Port: tx_start  out  1  one-cycle strobe handing tx_data to transmitter.
REQ-013 Port: tx_data  out  8  transmit holding register contents.
REQ-014 Port: baud_tick  out  1  one-cycle enable, once per bit period.

Function
REQ-015 databus SHALL be driven only when iocs=1 and iorw=1, combinationally from ioaddr in the same cycle; otherwise high-Z.
REQ-016 Read 00 SHALL return rx buffer; read 01 SHALL return {5'b0, ovr, tbr, rda}; read 10/11 SHALL return divisor[7:0]/[15:8].
REQ-017 Write 10/11 SHALL update divisor[7:0]/[15:8] at the clock edge ending the access; write 01 SHALL be ignored.
REQ-018 Any divisor write SHALL reload the baud counter with the new 16-bit divisor value on the next cycle.
REQ-019 Baud counter SHALL decrement each cycle and assert baud_tick for one cycle when it reaches 0, then reload; period = divisor+1 cycles.
REQ-020 Divisor 0 SHALL yield baud_tick every cycle.
REQ-021 rx_valid SHALL load rx buffer and set rda=1 at the next edge.
REQ-022 Read of 00 SHALL clear rda at the end of the access cycle.
REQ-023 rx_valid in the same cycle as a read of 00: bus returns old byte, buffer takes new byte, rda stays 1.
REQ-024 rx_valid while rda=1 (no simultaneous read) SHALL overwrite buffer and set ovr=1; ovr SHALL clear on read of 01.
REQ-025 Write 00 with tbr=1 SHALL load tx_data and clear tbr; write 00 with tbr=0 SHALL be discarded.
REQ-026 Transmit FSM states: IDLE (tbr=1), FULL (holding loaded), HANDOFF (tx_start=1 for exactly one cycle).
REQ-027 FULL->HANDOFF when tx_busy=0; HANDOFF->IDLE unconditionally, tbr=1 again from the following cycle.
REQ-028 tx_start SHALL never assert while tx_busy=1; tx_data SHALL remain stable through HANDOFF.
REQ-029 Accesses with iocs=0 SHALL have no side effects regardless of iorw/ioaddr.

Reset
REQ-030 On rst_n=0: rda=0, ovr=0, tbr=1, tx_start=0, baud_tick=0, tx_data=0, rx buffer=0, FSM=IDLE.
REQ-031 On rst_n=0: divisor=16'd10416 and baud counter=16'd10416 (4800 baud at 50 MHz).
REQ-032 Reset mid-handoff or mid-access SHALL abort immediately; no tx_start after reset release until a new write 00.

Structure
REQ-033 Package spart_pkg SHALL hold the register-address constants (DATA, STATUS, DB_LO, DB_HI), the transmit-state enum, and the reset divisor constant.
REQ-034 The baud counter SHALL be a sub-module spart_baud_gen (divisor, reload strobe in; baud_tick out).

Verification
REQ-035 Reset, no access -> tbr=1, rda=0, baud_tick every 10417 cycles.
REQ-036 Write 10=0x15, 11=0x05 -> read 10/11 return 0x15/0x05; baud_tick period becomes 1302 cycles from the reload.
REQ-037 rx_valid with rx_data=0xA5 -> rda=1; read 00 returns 0xA5; rda=0 next cycle.
REQ-038 Two rx_valid (0x11, 0x22) with no read -> read 01 returns 0x05; read 00 returns 0x22; following read 01 returns 0x02.
REQ-039 tx_busy=1, write 00=0x3C -> tbr=0, no tx_start; drop tx_busy -> single tx_start with tx_data=0x3C, tbr=1 next cycle; second write while tbr=0 is discarded.
REQ-040 Pulse rst_n low during HANDOFF -> tx_start=0 immediately, tbr=1, divisor read back 10416.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART bus interface: register map,
// transmit-side state encoding and the power-on baud divisor.
package spart_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] DATA   = 2'b00;
    localparam logic [1:0] STATUS = 2'b01;
    localparam logic [1:0] DB_LO  = 2'b10;
    localparam logic [1:0] DB_HI  = 2'b11;

    // 4800 baud from a 50 MHz clock
    localparam logic [15:0] RESET_DIVISOR = 16'd10416;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_FULL,
        TX_HANDOFF
    } tx_state_t;

    function automatic logic [DATA_W-1:0] status_byte(input logic ovr,
                                                      input logic tbr,
                                                      input logic rda);
        return {5'b0, ovr, tbr, rda};
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Down-counting baud generator: one-cycle tick every divisor+1 cycles,
// restarted from the current divisor whenever reload is strobed.
module spart_baud_gen
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    input  logic        reload,
    output logic        baud_tick
);

    logic [15:0] cnt;

    // reload beats terminal count so a new divisor always restarts a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= RESET_DIVISOR;
            baud_tick <= 1'b0;
        end else if (reload) begin
            cnt       <= divisor;
            baud_tick <= 1'b0;
        end else if (cnt == 16'd0) begin
            cnt       <= divisor;
            baud_tick <= 1'b1;
        end else begin
            cnt       <= cnt - 16'd1;
            baud_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/spart_bus_if.sv
// SPART processor-side bus interface: register file, receive buffer with
// overrun tracking, transmit holding register with handoff FSM, baud divisor.
module spart_bus_if
    import spart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    inout  wire  [DATA_W-1:0] databus,
    output logic              rda,
    output logic              tbr,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              baud_tick
);

    logic              bus_rd;
    logic              bus_wr;
    logic              rd_rx;
    logic              rd_stat;
    logic              wr_div;
    logic              div_wr_p1;
    logic              ovr;
    logic              tx_load;
    logic [15:0]       divisor;
    logic [DATA_W-1:0] rx_buf;
    logic [DATA_W-1:0] rd_data;
    tx_state_t         state;
    tx_state_t         state_nxt;

    assign bus_rd  = iocs &  iorw;
    assign bus_wr  = iocs & ~iorw;
    assign rd_rx   = bus_rd && (ioaddr == DATA);
    assign rd_stat = bus_rd && (ioaddr == STATUS);
    assign wr_div  = bus_wr && ((ioaddr == DB_LO) || (ioaddr == DB_HI));

    always_comb begin
        rd_data = '0;
        unique case (ioaddr)
            DATA:    rd_data = rx_buf;
            STATUS:  rd_data = status_byte(ovr, tbr, rda);
            DB_LO:   rd_data = divisor[7:0];
            DB_HI:   rd_data = divisor[15:8];
            default: rd_data = '0;
        endcase
    end

    assign databus = bus_rd ? rd_data : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor   <= RESET_DIVISOR;
            div_wr_p1 <= 1'b0;
        end else begin
            if (bus_wr && (ioaddr == DB_LO)) divisor[7:0]  <= databus;
            if (bus_wr && (ioaddr == DB_HI)) divisor[15:8] <= databus;
            div_wr_p1 <= wr_div;
        end
    end

    // A new byte arriving during a data read keeps rda set and is not an overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_buf <= '0;
            rda    <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            if (rx_valid) begin
                rx_buf <= rx_data;
                rda    <= 1'b1;
            end else if (rd_rx) begin
                rda    <= 1'b0;
            end
            if (rx_valid && rda && !rd_rx)
                ovr <= 1'b1;
            else if (rd_stat)
                ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            if (tx_load) tx_data <= databus;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_load   = 1'b0;
        tbr       = 1'b0;
        tx_start  = 1'b0;
        unique case (state)
            TX_IDLE: begin
                tbr = 1'b1;
                if (bus_wr && (ioaddr == DATA)) begin
                    tx_load   = 1'b1;
                    state_nxt = TX_FULL;
                end
            end
            TX_FULL: begin
                if (!tx_busy) state_nxt = TX_HANDOFF;
            end
            TX_HANDOFF: begin
                tx_start  = ~tx_busy;
                state_nxt = TX_IDLE;
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    spart_baud_gen u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .divisor   (divisor),
        .reload    (div_wr_p1),
        .baud_tick (baud_tick)
    );

endmodule

// File: tb/tb_spart_bus_if.sv
// Directed bench for spart_bus_if: register access, baud timing, receive
// overrun handling, transmit handoff and reset abort.
module tb_spart_bus_if;
    import spart_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       baud_tick;

    logic       tb_en;
    logic [7:0] tb_val;

    int n_pass;
    int n_total;

    assign databus = tb_en ? tb_val : 8'bz;

    spart_bus_if dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .rda       (rda),
        .tbr       (tbr),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .baud_tick (baud_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_val = d; tb_en = 1'b1;
        step();
        iocs = 1'b0; tb_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1;
        d = databus;
        step();
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!baud_tick && n < limit);
    endtask

    initial begin
        logic [7:0] rd;
        int         n;
        int         cnt;

        n_pass = 0; n_total = 0;
        rst_n = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        tb_en = 1'b0; tb_val = 8'h00;

        #2 rst_n = 1'b0;
        #3;
        check("rst_tbr", tbr, 1);
        check("rst_rda", rda, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_baud_tick", baud_tick, 0);
        check("rst_tx_data", tx_data, 8'h00);
        step(); step();
        rst_n = 1'b1;

        wait_tick(20000, n);
        check("baud_first_tick", n, 10417);
        wait_tick(20000, n);
        check("baud_reset_period", n, 10417);

        bus_read(DB_LO, rd); check("rst_div_lo", rd, 8'hB0);
        bus_read(DB_HI, rd); check("rst_div_hi", rd, 8'h28);
        bus_read(STATUS, rd); check("idle_status", rd, 8'h02);
        bus_read(DATA, rd); check("rst_rx_buf", rd, 8'h00);

        rx_pulse(8'hA5);
        check("rx_rda_set", rda, 1);
        bus_read(STATUS, rd); check("rx_status", rd, 8'h03);
        bus_read(DATA, rd); check("rx_data_read", rd, 8'hA5);
        check("rx_rda_clr", rda, 0);

        rx_pulse(8'h11);
        rx_valid = 1'b1; rx_data = 8'h77;
        iocs = 1'b1; iorw = 1'b1; ioaddr = DATA;
        #1 rd = databus;
        step();
        rx_valid = 1'b0; iocs = 1'b0; iorw = 1'b0;
        check("sim_old_byte", rd, 8'h11);
        check("sim_rda_kept", rda, 1);
        bus_read(STATUS, rd); check("sim_no_ovr", rd, 8'h03);
        bus_read(DATA, rd); check("sim_new_byte", rd, 8'h77);

        iocs = 1'b0; iorw = 1'b0; ioaddr = DB_LO; tb_val = 8'hFF; tb_en = 1'b1;
        step();
        ioaddr = DATA;
        step();
        iorw = 1'b1; ioaddr = DB_LO; tb_val = 8'hA0;
        #1 check("nocs_no_drive", databus, 8'hA0);
        step();
        tb_en = 1'b0; iorw = 1'b0;
        bus_read(DB_LO, rd); check("nocs_div_kept", rd, 8'hB0);
        check("nocs_tbr", tbr, 1);
        check("nocs_tx_data", tx_data, 8'h00);

        bus_write(STATUS, 8'hFF);
        bus_read(STATUS, rd); check("status_wr_ignored", rd, 8'h02);

        bus_write(DB_LO, 8'h15);
        bus_write(DB_HI, 8'h05);
        wait_tick(5000, n);
        check("baud_reload_first", n, 1303);
        wait_tick(5000, n);
        check("baud_new_period", n, 1302);
        bus_read(DB_LO, rd); check("div_lo", rd, 8'h15);
        bus_read(DB_HI, rd); check("div_hi", rd, 8'h05);

        bus_write(DB_LO, 8'h00);
        bus_write(DB_HI, 8'h00);
        step();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (baud_tick) cnt++;
        end
        check("div0_every_cycle", cnt, 4);

        tx_busy = 1'b1;
        bus_write(DATA, 8'h3C);
        check("tx_tbr_clr", tbr, 0);
        check("tx_data_load", tx_data, 8'h3C);
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        bus_read(STATUS, rd); check("ovr_status", rd, 8'h05);
        bus_read(DATA, rd); check("ovr_last_byte", rd, 8'h22);
        bus_write(DATA, 8'h99);
        check("tx_discard", tx_data, 8'h3C);
        check("tx_hold_busy", tx_start, 0);
        tx_busy = 1'b0;
        step();
        check("tx_start_pulse", tx_start, 1);
        check("tx_data_handoff", tx_data, 8'h3C);
        check("tx_tbr_handoff", tbr, 0);
        step();
        check("tx_start_end", tx_start, 0);
        check("tx_tbr_back", tbr, 1);
        bus_read(STATUS, rd); check("ovr_cleared", rd, 8'h02);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (tx_start) cnt++;
        end
        check("tx_single_start", cnt, 0);

        bus_write(DATA, 8'h5A);
        check("abort_full", tx_start, 0);
        step();
        check("abort_handoff", tx_start, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx_start", tx_start, 0);
        check("abort_tbr", tbr, 1);
        check("abort_tx_data", tx_data, 8'h00);
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_start) cnt++;
        end
        check("abort_no_start", cnt, 0);
        bus_read(DB_LO, rd); check("abort_div_lo", rd, 8'hB0);
        bus_read(DB_HI, rd); check("abort_div_hi", rd, 8'h28);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
